spi_master: RTL and testbench

SPI master that issues command frames to `SPI_slave` over SS_n/MOSI/MISO, clocked on the common system `clk`; no separate SCLK. It accepts one command per valid/ready handshake, serialises the 2-bit op plus 8-bit payload MSB-first, and collects the 8-bit read-back for READ_DATA frames. It is the bench-side and SoC-side initiator that drives the slave/RAM pair.

---
 rtl/shared_pkg.sv | 23 ++
 rtl/spi_defines.svh | 8 +
 rtl/spi_master_shifter.sv | 34 +++
 rtl/spi_master_sva.sv | 28 ++
 rtl/spi_master.sv | 187 ++++++++++++++++++
 tb/tb_spi_master.sv | 248 ++++++++++++++++++++++++
 6 files changed

// File: rtl/shared_pkg.sv
// Types and frame geometry shared by the SPI master, its shifter and its checker.
package shared_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT,
        WAIT,
        READ,
        GAP
    } master_state_e;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    localparam int FRAME_BITS = 10;
    localparam int RD_BITS    = 8;

endpackage

// File: rtl/spi_defines.svh
// Build-time defaults for the SPI master timing knobs.
`ifndef SPI_DEFINES_SVH
`define SPI_DEFINES_SVH

`define SPI_READ_LAT_DEFAULT 2
`define SPI_IDLE_GAP_DEFAULT 1

`endif

// File: rtl/spi_master_shifter.sv
// TX parallel-load shift register (op+payload, MSB first) and RX shift register for read-back.
module spi_master_shifter
    import shared_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_data,
    input  logic                  shift_tx,
    input  logic                  shift_rx,
    input  logic                  MISO,
    output logic                  tx_msb,
    output logic [RD_BITS-1:0]    rx_word
);

    logic [FRAME_BITS-1:0] tx_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            rx_word <= '0;
        end else begin
            if (load)
                tx_sr <= load_data;
            else if (shift_tx)
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
            if (shift_rx)
                rx_word <= {rx_word[RD_BITS-2:0], MISO};
        end
    end

    assign tx_msb = tx_sr[FRAME_BITS-1];

endmodule

// File: rtl/spi_master_sva.sv
// Protocol checks on the master: select/ready interlock, gap hold, response origin.
module spi_master_sva
    import shared_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    input master_state_e       state,
    input logic                SS_n,
    input logic                cmd_ready,
    input logic                rsp_valid,
    input logic [RD_BITS-1:0]  rsp_data,
    input logic [RD_BITS-1:0]  rx_word
);

    a_gap_ss_high: assert property (@(posedge clk) disable iff (!rst_n)
        (state == GAP) |-> SS_n);

    a_ready_when_deselected: assert property (@(posedge clk) disable iff (!rst_n)
        !SS_n |-> !cmd_ready);

    a_rsp_after_read: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> ($past(state) == READ));

    // The response register and the RX shifter capture the same final bit on the same edge.
    a_rsp_matches_rx: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (rsp_data == rx_word));

endmodule

// File: rtl/spi_master.sv
// SPI command-frame initiator: SEL(2) + 10 frame bits, optional read-back after READ_LAT, then idle gap.
`include "spi_defines.svh"

module spi_master
    import shared_pkg::*;
#(
    parameter int READ_LAT = `SPI_READ_LAT_DEFAULT,
    parameter int IDLE_GAP = `SPI_IDLE_GAP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [7:0]         cmd_data,
    output logic               rsp_valid,
    output logic [RD_BITS-1:0] rsp_data,
    output logic               busy,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    master_state_e         state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  rd_frame, rd_frame_n;
    logic                  ss_n_n, mosi_n, ready_n, busy_n, rsp_valid_n;
    logic                  rsp_load, load, shift_tx, shift_rx, end_frame;
    logic [FRAME_BITS-1:0] load_data;
    logic                  tx_msb;
    logic [RD_BITS-1:0]    rx_word;

    // RD_DATA payload is meaningless to the slave, so it goes out as zeros.
    assign load_data = {cmd_op, (cmd_op == RD_DATA) ? 8'h00 : cmd_data};

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rd_frame_n  = rd_frame;
        ss_n_n      = 1'b0;
        mosi_n      = 1'b0;
        ready_n     = 1'b0;
        busy_n      = 1'b1;
        rsp_valid_n = 1'b0;
        rsp_load    = 1'b0;
        load        = 1'b0;
        shift_tx    = 1'b0;
        shift_rx    = 1'b0;
        end_frame   = 1'b0;
        case (state)
            IDLE: begin
                ss_n_n  = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    load       = 1'b1;
                    state_n    = SEL;
                    cnt_n      = 4'd1;
                    rd_frame_n = (cmd_op == RD_DATA);
                    ss_n_n     = 1'b0;
                    mosi_n     = cmd_op[1];
                    ready_n    = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            SEL: begin
                mosi_n = tx_msb;
                if (cnt == 4'd0) begin
                    state_n  = SHIFT;
                    cnt_n    = 4'(FRAME_BITS - 1);
                    shift_tx = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            SHIFT: begin
                if (cnt == 4'd0) begin
                    if (rd_frame) begin
                        state_n = WAIT;
                        cnt_n   = 4'(READ_LAT - 1);
                    end else begin
                        end_frame = 1'b1;
                    end
                end else begin
                    mosi_n   = tx_msb;
                    shift_tx = 1'b1;
                    cnt_n    = cnt - 4'd1;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = READ;
                    cnt_n   = 4'(RD_BITS - 1);
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            READ: begin
                shift_rx = 1'b1;
                if (cnt == 4'd0) begin
                    rsp_load    = 1'b1;
                    rsp_valid_n = 1'b1;
                    end_frame   = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            GAP: begin
                ss_n_n = 1'b1;
                if (cnt == 4'd0) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                ss_n_n  = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
        // The IDLE cycle itself counts as the last gap cycle, so GAP only covers the surplus.
        if (end_frame) begin
            ss_n_n = 1'b1;
            if (IDLE_GAP == 1) begin
                state_n = IDLE;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end else begin
                state_n = GAP;
                cnt_n   = 4'(IDLE_GAP - 2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_frame  <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rd_frame  <= rd_frame_n;
            SS_n      <= ss_n_n;
            MOSI      <= mosi_n;
            cmd_ready <= ready_n;
            busy      <= busy_n;
            rsp_valid <= rsp_valid_n;
            if (rsp_load)
                rsp_data <= {rx_word[RD_BITS-2:0], MISO};
        end
    end

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .shift_tx  (shift_tx),
        .shift_rx  (shift_rx),
        .MISO      (MISO),
        .tx_msb    (tx_msb),
        .rx_word   (rx_word)
    );

    spi_master_sva u_sva (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .SS_n      (SS_n),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rx_word   (rx_word)
    );

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench: a behavioural slave/RAM captures frames and returns read data; monitor checks against queues.
module tb_spi_master;
    import shared_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
    logic [1:0][1:0] cmd_op;
    logic [1:0][7:0] cmd_data, rsp_data;

    spi_master #(.READ_LAT(2), .IDLE_GAP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]));

    spi_master #(.READ_LAT(4), .IDLE_GAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]));

    typedef struct { int inst; logic [9:0] frame; } frm_t;
    typedef struct { int inst; logic [7:0] data; int cyc; } rsp_t;
    typedef struct { string name; int act; int exp; } chk_t;

    frm_t frm_q[$];
    rsp_t rsp_q[$];
    chk_t chk_q[$];

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rl_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function void cmp(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic post(input string name, input int act, input int exp);
        chk_t c;
        c.name = name; c.act = act; c.exp = exp;
        chk_q.push_back(c);
    endtask

    // Slave/RAM model state, one set per DUT
    int         sl_cnt[2];
    int         hi_run[2];
    int         last_hi[2];
    logic [9:0] sl_sh[2];
    logic [1:0] sl_op[2];
    logic [7:0] sl_addr[2], rd_addr[2], rd_word[2];
    bit         rd_act[2];
    logic [7:0] mem[2][256];

    always @(negedge clk) begin
        chk_t c;
        frm_t f;
        rsp_t r;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        for (int i = 0; i < 2; i++) begin
            int rl;
            rl = rl_of(i);
            if (rsp_valid[i]) begin
                if (rsp_q.size() == 0) cmp($sformatf("rsp_unexpected_dut%0d", i), 1, 0);
                else begin
                    r = rsp_q.pop_front();
                    cmp("rsp_inst", i, r.inst);
                    cmp("rsp_data", int'(rsp_data[i]), int'(r.data));
                    cmp("rsp_cycle", cyc, r.cyc);
                end
            end
            if (ss_n[i]) begin
                if (sl_cnt[i] >= 12)
                    cmp("frame_len", sl_cnt[i], (sl_op[i] == 2'b11) ? 12 + rl + 8 : 12);
                sl_cnt[i] = 0;
                rd_act[i] = 1'b0;
                miso[i]   = 1'b0;
                hi_run[i]++;
            end else begin
                if (sl_cnt[i] == 0) begin
                    last_hi[i] = hi_run[i];
                    hi_run[i]  = 0;
                end
                sl_cnt[i]++;
                if (sl_cnt[i] == 2 && frm_q.size() > 0)
                    cmp("sel_mosi", int'(mosi[i]), int'(frm_q[0].frame[9]));
                if (sl_cnt[i] >= 3 && sl_cnt[i] <= 12)
                    sl_sh[i] = {sl_sh[i][8:0], mosi[i]};
                if (sl_cnt[i] == 12) begin
                    sl_op[i] = sl_sh[i][9:8];
                    if (frm_q.size() == 0) cmp($sformatf("frame_unexpected_dut%0d", i), 1, 0);
                    else begin
                        f = frm_q.pop_front();
                        cmp("frame_inst", i, f.inst);
                        cmp("frame_bits", int'(sl_sh[i]), int'(f.frame));
                    end
                    case (sl_op[i])
                        2'b00: sl_addr[i] = sl_sh[i][7:0];
                        2'b01: mem[i][sl_addr[i]] = sl_sh[i][7:0];
                        2'b10: rd_addr[i] = sl_sh[i][7:0];
                        default: begin
                            rd_word[i] = mem[i][rd_addr[i]];
                            rd_act[i]  = 1'b1;
                        end
                    endcase
                end
                if (rd_act[i] && sl_cnt[i] >= 13 + rl && sl_cnt[i] <= 20 + rl)
                    miso[i] = rd_word[i][20 + rl - sl_cnt[i]];
                else
                    miso[i] = 1'b0;
            end
        end
    end

    task automatic send(input int i, input logic [1:0] op, input logic [7:0] d, input bit push,
                        input bit hold, input logic [7:0] exp_rsp, output int acc);
        int   n;
        frm_t f;
        rsp_t r;
        cmd_op[i] = op; cmd_data[i] = d; cmd_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready[i] && n < 200);
        if (!cmd_ready[i]) begin
            post("accept_timeout", 0, 1);
            cmd_valid[i] = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        if (!hold) cmd_valid[i] = 1'b0;
        if (push) begin
            f.inst = i;
            f.frame = {op, (op == 2'b11) ? 8'h00 : d};
            frm_q.push_back(f);
            if (op == 2'b11) begin
                r.inst = i; r.data = exp_rsp; r.cyc = acc + 12 + rl_of(i) + 8;
                rsp_q.push_back(r);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a0, a1, b0, b1, b2;
        cmd_valid = '0; cmd_op = '0; cmd_data = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            post("rst_ready", int'(cmd_ready[i]), 1);
            post("rst_ssn", int'(ss_n[i]), 1);
            post("rst_mosi", int'(mosi[i]), 0);
            post("rst_busy", int'(busy[i]), 0);
            post("rst_rsp_valid", int'(rsp_valid[i]), 0);
            post("rst_rsp_data", int'(rsp_data[i]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-SHIFT on a read frame: outputs drop without a clock edge, no response later
        send(0, 2'b11, 8'h00, 1'b0, 1'b0, 8'h00, a);
        repeat (5) @(posedge clk);
        #3;
        post("pre_rst_ssn", int'(ss_n[0]), 0);
        rst_n = 1'b0;
        #1;
        post("async_rst_ssn", int'(ss_n[0]), 1);
        post("async_rst_mosi", int'(mosi[0]), 0);
        post("async_rst_ready", int'(cmd_ready[0]), 1);
        post("async_rst_rsp_valid", int'(rsp_valid[0]), 0);
        post("async_rst_busy", int'(busy[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        // WR_ADDR A5: frame bits 0,0,1,0,1,0,0,1,0,1
        send(0, 2'b00, 8'hA5, 1'b1, 1'b0, 8'h00, a);

        // Write then read back, RD_DATA period to the next accept is 23
        send(0, 2'b00, 8'h3C, 1'b1, 1'b0, 8'h00, a);
        send(0, 2'b01, 8'h5A, 1'b1, 1'b0, 8'h00, a);
        send(0, 2'b10, 8'h3C, 1'b1, 1'b0, 8'h00, a);
        send(0, 2'b11, 8'hFF, 1'b1, 1'b1, 8'h5A, a0);
        send(0, 2'b00, 8'h01, 1'b1, 1'b0, 8'h00, a1);
        post("rd_period", a1 - a0, 23);

        // Back-to-back writes with cmd_valid held
        send(0, 2'b00, 8'h11, 1'b1, 1'b1, 8'h00, b0);
        send(0, 2'b01, 8'h22, 1'b1, 1'b1, 8'h00, b1);
        send(0, 2'b00, 8'h33, 1'b1, 1'b0, 8'h00, b2);
        post("b2b_period1", b1 - b0, 13);
        post("b2b_period2", b2 - b1, 13);
        @(negedge clk); #1;
        post("b2b_ss_high_cycles", last_hi[0], 1);

        // Request pulsed mid-frame must be ignored
        send(0, 2'b00, 8'h77, 1'b1, 1'b0, 8'h00, a);
        repeat (4) @(posedge clk);
        #1;
        cmd_op[0] = 2'b11; cmd_data[0] = 8'hEE; cmd_valid[0] = 1'b1;
        @(negedge clk);
        post("ign_ready", int'(cmd_ready[0]), 0);
        post("ign_busy", int'(busy[0]), 1);
        post("ign_ssn", int'(ss_n[0]), 0);
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;

        // READ_LAT=4 instance: read back C3, period 25
        send(1, 2'b00, 8'h10, 1'b1, 1'b0, 8'h00, a);
        send(1, 2'b01, 8'hC3, 1'b1, 1'b0, 8'h00, a);
        send(1, 2'b10, 8'h10, 1'b1, 1'b0, 8'h00, a);
        send(1, 2'b11, 8'h00, 1'b1, 1'b1, 8'hC3, a0);
        send(1, 2'b00, 8'h55, 1'b1, 1'b0, 8'h00, a1);
        post("lat4_period", a1 - a0, 25);

        repeat (40) @(posedge clk);
        #1;
        post("frames_left", frm_q.size(), 0);
        post("rsps_left", rsp_q.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
